// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - start/stop/pause count sequencer with terminal count and auto-reload
//
// Purpose:
//   Owns a WIDTH-bit count register and sequences it through IDLE/RUN/PAUSE/DONE.
//   The run counts up from 0 to the latched limit, or down from the latched limit
//   to 0. At the terminal value it either finishes (one-shot) or restarts (reload).
//   Optional build macro: COUNTER_SEQ_PRESCALE_EN. When it is defined, the count
//   and terminal actions happen only once every PRESCALE cycles of RUN.
//
// Ports:
//   CLK        in   system clock, all state changes on posedge
//   reset      in   synchronous active-high reset, priority over everything
//   start      in   begin a run (IDLE only)
//   stop       in   abort the run (RUN/PAUSE only)
//   pause      in   level, hold the count while high
//   cfg_load   in   latch cfg_limit/cfg_dir/cfg_reload (IDLE only)
//   cfg_limit  in   terminal value (up) or start value (down), WIDTH bits
//   cfg_dir    in   0 = up, 1 = down
//   cfg_reload in   1 = auto-reload at terminal, 0 = one-shot
//   out        out  registered count, WIDTH bits
//   busy       out  high in RUN or PAUSE
//   done       out  one-cycle pulse at the terminal action
//   state      out  IDLE=00, RUN=01, PAUSE=10, DONE=11
module counter_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_dir,
  input  logic             cfg_reload,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_limit;
  logic             r_dir;
  logic             r_reload;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_ld_limit;
  logic             w_ld_dir;
  logic [WIDTH-1:0] w_start_val;
  logic [WIDTH-1:0] w_reload_val;
  logic [WIDTH-1:0] w_term_val;
  logic [WIDTH-1:0] w_step_val;
  logic             w_at_term;
  logic             w_tick;

  // A start in IDLE sees the config being loaded on the same edge, so the
  // start value is derived from the incoming cfg when cfg_load is high.
  assign w_ld_limit   = cfg_load ? cfg_limit : r_limit;
  assign w_ld_dir     = cfg_load ? cfg_dir   : r_dir;
  assign w_start_val  = w_ld_dir ? w_ld_limit : '0;

  // Inside a run only the latched config matters.
  assign w_reload_val = r_dir ? r_limit : '0;
  assign w_term_val   = r_dir ? '0 : r_limit;
  assign w_at_term    = (r_out == w_term_val);
  assign w_step_val   = r_dir ? (r_out - ONE) : (r_out + ONE);

`ifdef COUNTER_SEQ_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] r_presc;

  assign w_tick = (r_presc == PS_LAST);

  // Held at zero outside a run so every start begins a fresh period; a tick
  // wraps it to zero, which also covers the reload edge.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_presc <= '0;
    end else if (r_state == ST_IDLE || r_state == ST_DONE) begin
      r_presc <= '0;
    end else if (stop) begin
      r_presc <= '0;
    end else if (r_state == ST_RUN && !pause) begin
      r_presc <= w_tick ? '0 : (r_presc + PS_ONE);
    end
  end
`else
  // Every cycle is a tick; PRESCALE is at least 1 so this is a constant 1.
  assign w_tick = (PRESCALE > 0);
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_out    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_limit  <= ALL_ONES;
      r_dir    <= 1'b0;
      r_reload <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_load) begin
            r_limit  <= cfg_limit;
            r_dir    <= cfg_dir;
            r_reload <= cfg_reload;
          end
          if (start) begin
            r_out   <= w_start_val;
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (pause) begin
            r_state <= ST_PAUSE;
          end else if (w_tick) begin
            if (w_at_term) begin
              r_done <= 1'b1;
              if (r_reload) begin
                r_out <= w_reload_val;
              end else begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_out <= w_step_val;
            end
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (!pause) begin
            // Resume edge only changes state; the count advances from the next edge.
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out   = r_out;
  assign busy  = r_busy;
  assign done  = r_done;
  assign state = r_state;

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that owns and sequences a WIDTH-bit count register: start/stop/pause control, programmable terminal count, up/down direction, one-shot or auto-reload.
- Sits between control logic and the counter datapath.
- Exports the count value plus busy/done status for downstream consumers and testbenches.

Parameters:
- WIDTH, 4, count and limit width in bits (>=2).
- PRESCALE, 2, tick divider ratio (>=1); used only when COUNTER_SEQ_PRESCALE_EN is defined.

Ports:
- CLK  input  1  system clock, all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a count run; honoured only in IDLE.
- stop  input  1  abort the run; honoured in RUN/PAUSE.
- pause  input  1  level; hold the count while high.
- cfg_load  input  1  latch the cfg_* inputs; honoured only in IDLE.
- cfg_limit  input  WIDTH  terminal value for up mode, start value for down mode.
- cfg_dir  input  1  0 = up, 1 = down.
- cfg_reload  input  1  1 = auto-reload at terminal, 0 = one-shot.
- out  output  WIDTH  current count (registered).
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse at terminal.
- state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Reset, sampled at posedge CLK while reset=1:
  - state=IDLE, out=0, busy=0, done=0.
  - limit_r=2^WIDTH-1, dir_r=0, reload_r=0.
  - Reset has priority over all other inputs. Reset mid-run aborts immediately with no done pulse.
- Config: cfg_load=1 in IDLE latches limit_r/dir_r/reload_r at that edge. Ignored in any other state. The run always uses the latched values, never the live cfg_* inputs.
- Start value SV = 0 if dir_r=0, limit_r if dir_r=1. Terminal value TV = limit_r if up, 0 if down.
- IDLE:
  - start=1 -> next edge: out=SV, state=RUN, busy=1.
  - cfg_load and start on the same edge: config latches first, and SV uses the new values.
- RUN, priority stop > pause > terminal > count:
  - stop -> IDLE, out holds, busy=0, no done.
  - pause -> PAUSE, out holds (no advance on that edge).
  - out==TV, one-shot -> DONE, done=1, out holds TV, busy=0.
  - out==TV, reload -> out=SV, stay RUN, done=1 for one cycle.
  - Otherwise out = out+1 (up) or out-1 (down), modulo 2^WIDTH arithmetic.
  - The terminal compare prevents wrap. limit_r=2^WIDTH-1 in up mode runs the full range.
- PAUSE:
  - stop -> IDLE, no done.
  - pause=0 -> RUN; out does not advance on the resume edge.
  - Otherwise hold.
- DONE: lasts exactly one cycle, then IDLE with done=0 and out holding TV.
- Latency:
  - start sampled at edge N -> out=SV after N; first advance at N+1.
  - Terminal visible after edge M -> done=1 after edge M+1.
- Degenerate case: limit_r=0 gives SV==TV, so done fires one cycle after the start edge.
- start is ignored outside IDLE. stop/pause are ignored in IDLE and DONE.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro COUNTER_SEQ_PRESCALE_EN.
- Defined:
  - An internal prescaler generates tick once every PRESCALE cycles in RUN.
  - The prescaler clears to 0 on the start edge and on the reload edge.
  - The prescaler holds in PAUSE and resets on stop/reset.
  - The count advance and the terminal action occur only on tick edges; stop and pause remain immediate.
- Undefined: tick is tied to 1 and PRESCALE is unused. Timing is exactly as described in Behaviour.

Test Plan:
- Reset, then cfg_load limit=3, dir=0, reload=0, then start:
  - out sequence 0,1,2,3 on successive edges.
  - Next edge: done=1, state=11.
  - Next edge: state=00, out=3, done=0, busy=0.
- limit=2, dir=1, reload=1, start:
  - out = 2,1,0,2,1,0...
  - done=1 on each cycle following out=0; busy stays 1.
- Up run, limit=15: assert pause when out=5 for 3 cycles:
  - out holds 5 and state=10 for 3 cycles.
  - After release, out=5 for one more cycle, then 6.
- stop while out=7 during a run: next edge state=00, out=7, busy=0, done never asserted.
- reset=1 asserted mid-run with out=9: next edge out=0, state=00, limit_r=15.
  - A following start with no cfg_load counts 0..15, then done.
- With COUNTER_SEQ_PRESCALE_EN and PRESCALE=2, limit=2: out changes every 2 cycles (0,0,1,1,2,2), then done.
  - cfg_load asserted in RUN is ignored, checked by limit_r unchanged at the end of the run.
